priority_encoder_n_hs: RTL
==========================

Name: priority_encoder_n_hs

Overview:
- Parametrised, registered successor to the 4-to-2 line encoder.
- Sticky-latches N request lines and emits one encoded index at a time over a valid/ready handshake.
- Selection mode: fixed priority (highest index wins) or round-robin.
- Sits between request sources (interrupt or event lines) and a single consumer that must see every request exactly once.

Parameters:
- N, 8: number of request lines; legal for any N >= 2, including non-power-of-2.
- RR_MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- W (localparam, derived, not overridable): $clog2(N), width of the encoded index.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  request pulses or levels, OR'd into pending every cycle.
- out_valid  output  1  out_idx holds a pending request.
- out_idx  output  W  encoded index of the presented request.
- out_ready  input  1  consumer accepts; handshake = out_valid & out_ready at a rising edge.
- pending  output  N  registered sticky request vector, for debug and status.

Behaviour:
- Reset values (rst high at an edge): pending=0, out_valid=0, out_idx=0, RR pointer=N-1. req_in is ignored in any cycle rst is high. Reset mid-handshake drops the presented request with no completion.
- Pending update at every edge: pending <= (pending & ~served) | req_in.
  - served = onehot(out_idx) when a handshake occurs, else 0.
  - If req_in re-asserts the bit being served in the same cycle, that bit stays set (new request wins) and is presented again later.
- FSM has two states:
  - IDLE (out_valid=0): if pending != 0, load out_idx = pick(pending) and go to HOLD with out_valid=1.
  - HOLD (out_valid=1): out_idx and out_valid stay stable until a handshake; new higher-priority requests never change the presented index.
  - On handshake, compute rem = pending & ~served. If rem != 0, load out_idx = pick(rem) and stay in HOLD, giving back-to-back grants at one per cycle. Otherwise go to IDLE.
  - req_in arriving in the handshake cycle is not considered for that cycle's pick; it is picked from the next cycle.
- Latency: a request sampled at edge k sets pending at edge k. From IDLE, out_valid rises at edge k+1. Throughput is one grant per cycle while ready is held high.
- pick(v), fixed mode: highest set index of v.
- pick(v), RR mode: first set bit searching upward from (ptr+1) mod N, wrapping. ptr <= out_idx on each handshake only.
- out_idx is always < N. For non-power-of-2 N, the unused codes are never produced.
- out_ready high while out_valid=0 has no effect.
- Simultaneous requests on all N lines are each granted exactly once, in mode order.

Decomposition:
- Shared package: mode constants PRIO_FIXED=0 and PRIO_RR=1, plus the index-width helper function used for W.
- One natural sub-module: prio_pick_n.
  - Combinational find-first-set over an N-bit vector with a start offset; returns the index and a found flag.
  - Instantiated once in fixed mode (offset tie-off) and once in RR mode.
- FSM, pending register and pointer stay in the top module.

Test Plan:
- N=4, fixed, out_ready=1: pulse req_in=4'b0001, 4'b0010, 4'b0100, 4'b1000 at 20-cycle spacing -> out_idx 0, 1, 2, 3, each with a 1-cycle out_valid pulse one edge after pending sets.
- N=4, fixed, out_ready=0: req_in=4'b1010 for one cycle -> out_idx=3 held stable. Then req_in=4'b0100 -> idx stays 3 and pending=1110. Raise ready -> grants 3, 2, 1 back-to-back, then out_valid=0 and pending=0.
- N=8, RR, ready=1: req_in=8'hFF for one cycle -> grants 0, 1, ..., 7 on consecutive cycles. Then req_in=8'h81 -> grant 0 then 7 (pointer at 7, wrap).
- N=5 (non-power-of-2), fixed: req_in=5'b10000 -> out_idx=3'd4. No idx of 5-7 appears under random stimulus (assertion).
- Same-bit re-request: N=4, out_idx=2 presented, req_in=4'b0100 in the handshake cycle -> pending bit 2 remains set and out_idx=2 is presented again.
- Reset mid-operation: pending=4'b1111 with out_valid=1, assert rst one cycle with req_in=4'b1111 -> next cycle pending=0, out_valid=0, out_idx=0. Later RR grants start at index 0.

Source files
------------

// File: rtl/priority_encoder_n_hs_pkg.sv
// Shared definitions for the N-line handshaked priority encoder:
// selection-mode constants, FSM state type and the index-width helper.
package priority_encoder_n_hs_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // IDLE: nothing presented; HOLD: out_idx is presented with out_valid=1.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_t;

    // Width of an index into n lines; never below 1 bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick_n.sv
// Combinational find-first-set over an N-bit vector. The search starts at
// 'start' and walks upward (DESCEND=0) or downward (DESCEND=1), wrapping
// modulo N, so the returned index is always < N.
module prio_pick_n #(
    parameter int N       = 8,
    parameter int W       = 3,
    parameter bit DESCEND = 1'b0
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan all N positions in search order and keep the first hit.
    always_comb begin
        int pos;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            if (DESCEND) begin
                pos = (int'(start) + N - i) % N;
            end else begin
                pos = (int'(start) + i) % N;
            end
            if (!found && ((vec & (N'(1) << pos)) != '0)) begin
                idx   = W'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_n_hs.sv
// Registered N-line priority encoder with a valid/ready output.
// Requests are sticky-latched in 'pending' and presented one at a time.
//
// Handshake: out_valid/out_idx are registered and, once out_valid is high,
// stay stable until out_valid & out_ready is seen at a rising edge; that edge
// clears the granted bit (unless req_in re-asserts it in the same cycle) and
// either loads the next index from the remaining bits or returns to IDLE.
// out_ready while out_valid is low is ignored. out_valid mirrors the FSM state.
module priority_encoder_n_hs
    import priority_encoder_n_hs_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = PRIO_FIXED,
    localparam int W       = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pending
);

    enc_state_t   state;
    logic         handshake;
    logic [N-1:0] served;
    logic [N-1:0] rem;
    logic [W-1:0] pick_idx;
    logic         pick_found;

    assign out_valid = (state == ST_HOLD);
    assign handshake = (state == ST_HOLD) && out_ready;
    assign served    = handshake ? (N'(1) << out_idx) : '0;
    // In IDLE nothing is served, so rem is simply pending; new req_in is not
    // part of this cycle's pick.
    assign rem       = pending & ~served;

    generate
        if (RR_MODE == PRIO_RR) begin : g_rr
            logic [W-1:0] ptr;
            logic [W-1:0] rr_base;
            logic [W-1:0] rr_start;

            // On a handshake the index being granted becomes the new "last
            // served" position, so the next search begins just after it.
            assign rr_base  = handshake ? out_idx : ptr;
            assign rr_start = (rr_base == W'(N - 1)) ? '0 : rr_base + W'(1);

            prio_pick_n #(.N(N), .W(W), .DESCEND(1'b0)) u_pick (
                .vec   (rem),
                .start (rr_start),
                .idx   (pick_idx),
                .found (pick_found)
            );

            // Round-robin pointer: last granted index, reset to N-1 so the
            // first search starts at line 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr <= W'(N - 1);
                end else if (handshake) begin
                    ptr <= out_idx;
                end
            end
        end else begin : g_fixed
            prio_pick_n #(.N(N), .W(W), .DESCEND(1'b1)) u_pick (
                .vec   (rem),
                .start (W'(N - 1)),
                .idx   (pick_idx),
                .found (pick_found)
            );
        end
    endgenerate

    // Pending register and presentation FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            state   <= ST_IDLE;
            out_idx <= '0;
        end else begin
            pending <= rem | req_in;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        out_idx <= pick_idx;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (pick_found) begin
                            out_idx <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
